// File: rtl/sm2_pkg.sv
// Shared SM2 field constants, fold shift amounts and FSM state encoding.
package sm2_pkg;

  localparam int unsigned SM2_W = 256;
  localparam int unsigned SM2_XW = 512;

  localparam logic [SM2_W-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // 2^256 == 2^224 + 2^96 - 2^64 + 1 (mod p)
  localparam int unsigned FOLD_SH_224 = 224;
  localparam int unsigned FOLD_SH_96  = 96;
  localparam int unsigned FOLD_SH_64  = 64;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_FOLD = 1'b1;

endpackage

// File: rtl/sm2_fold_step.sv
// One SM2 fold: X -> L + H + (H<<96) - (H<<64) + (H<<224), purely combinational.
module sm2_fold_step
  import sm2_pkg::*;
(
  input  logic [SM2_XW-1:0] x_i,
  output logic [SM2_XW-1:0] x_o,
  output logic              hi_zero_o
);

  localparam int unsigned SUM_W = SM2_XW + 1;

  logic [SM2_W-1:0] hi;
  logic [SM2_W-1:0] lo;
  logic [SUM_W-1:0] sum;
  logic             unused_carry;

  // H<<96 always dominates H<<64, so the sum never goes negative.
  always_comb begin
    hi        = x_i[SM2_XW-1:SM2_W];
    lo        = x_i[SM2_W-1:0];
    sum       = SUM_W'(lo) + SUM_W'(hi)
              + (SUM_W'(hi) << FOLD_SH_96)
              + (SUM_W'(hi) << FOLD_SH_224)
              - (SUM_W'(hi) << FOLD_SH_64);
    x_o       = sum[SM2_XW-1:0];
    hi_zero_o = (hi == '0);
  end

  assign unused_carry = sum[SUM_W-1];

endmodule

// File: rtl/mod_red_sm2_fold.sv
// Sequential SM2 reduction of a 512b product: fold high half per cycle, then one conditional subtract.
// Optional feature macro: MODRED_DROP_FLAG_EN adds drop_o for starts ignored while busy.
module mod_red_sm2_fold
  import sm2_pkg::*;
#(
  parameter int unsigned MAX_FOLD = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mul_fin_i,
  input  logic [SM2_XW-1:0] mul_r_i,
  output logic              red_fin_o,
  output logic [SM2_W-1:0]  red_r_o,
`ifdef MODRED_DROP_FLAG_EN
  output logic              drop_o,
`endif
  output logic              busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_FOLD + 1);
  localparam int unsigned SUB_W = SM2_W + 1;

  state_t              state_q, state_d;
  logic [SM2_XW-1:0]   x_q, x_d;
  logic [CNT_W-1:0]    fold_cnt_q, fold_cnt_d;
  logic                red_fin_q, red_fin_d;
  logic [SM2_W-1:0]    red_r_q, red_r_d;

  logic [SM2_XW-1:0]   x_fold;
  logic                hi_zero;
  logic [SUB_W-1:0]    diff;
  logic [SM2_W-1:0]    red_final;
  logic                fold_limit;

  sm2_fold_step u_fold (
    .x_i       (x_q),
    .x_o       (x_fold),
    .hi_zero_o (hi_zero)
  );

  // Guard bit of the subtraction is the borrow: clear means X >= p.
  always_comb begin
    diff       = SUB_W'(x_q[SM2_W-1:0]) - SUB_W'(SM2_P);
    red_final  = diff[SUB_W-1] ? x_q[SM2_W-1:0] : diff[SM2_W-1:0];
    fold_limit = (fold_cnt_q == CNT_W'(MAX_FOLD));
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    fold_cnt_d = fold_cnt_q;
    red_fin_d  = 1'b0;
    red_r_d    = red_r_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_fin_i) begin
          x_d        = mul_r_i;
          fold_cnt_d = '0;
          state_d    = ST_FOLD;
        end
      end
      ST_FOLD: begin
        // Exit is also forced at the fold ceiling so hardware can never stall.
        if (!hi_zero && !fold_limit) begin
          x_d        = x_fold;
          fold_cnt_d = fold_cnt_q + CNT_W'(1);
        end else begin
          red_r_d   = red_final;
          red_fin_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      fold_cnt_q <= '0;
      red_fin_q  <= 1'b0;
      red_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      fold_cnt_q <= fold_cnt_d;
      red_fin_q  <= red_fin_d;
      red_r_q    <= red_r_d;
    end
  end

  assign red_fin_o = red_fin_q;
  assign red_r_o   = red_r_q;
  assign busy_o    = (state_q == ST_FOLD);

`ifdef MODRED_DROP_FLAG_EN
  logic drop_q, drop_d;

  always_comb begin
    drop_d = mul_fin_i && (state_q == ST_FOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_o = drop_q;
`endif

`ifndef SYNTHESIS
  fold_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ST_FOLD) && !hi_zero && fold_limit))
    else $fatal(1, "sm2 fold ceiling reached with nonzero high half");
`endif

endmodule
